// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: every output, including s_ready, comes from a flop,
// so neither the ready path nor the data path is combinational through this block.
module skid_buffer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       level
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] skid;
   logic             xfer_in;
   logic             xfer_out;

   assign xfer_in  = s_valid & s_ready;
   assign xfer_out = m_valid & m_ready;

   // Outputs are updated alongside the state so they stay registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         m_valid <= 1'b0;
         s_ready <= 1'b1;
         level   <= 2'd0;
         m_data  <= '0;
         skid    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (xfer_in) begin
                  m_data  <= s_data;
                  m_valid <= 1'b1;
                  level   <= 2'd1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (xfer_in && xfer_out) begin
                  m_data <= s_data;
               end else if (xfer_in) begin
                  // Downstream stalled: park the new word behind the one on m_data.
                  skid    <= s_data;
                  s_ready <= 1'b0;
                  level   <= 2'd2;
                  state   <= FULL;
               end else if (xfer_out) begin
                  m_valid <= 1'b0;
                  level   <= 2'd0;
                  state   <= EMPTY;
               end
            end
            FULL: begin
               if (xfer_out) begin
                  m_data  <= skid;
                  s_ready <= 1'b1;
                  level   <= 2'd1;
                  state   <= BUSY;
               end
            end
            default: begin
               m_valid <= 1'b0;
               s_ready <= 1'b1;
               level   <= 2'd0;
               state   <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: directed scenarios on a 32-bit slice, then
// random traffic on 8-bit and 1-bit slices, each tracked by its own reference queue.
module tb_skid_buffer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        s_valid, s_ready, m_valid, m_ready;
   logic [31:0] s_data, m_data;
   logic [1:0]  level;
   logic        s_valid8, s_ready8, m_valid8, m_ready8;
   logic [7:0]  s_data8, m_data8;
   logic [1:0]  level8;
   logic        s_valid1, s_ready1, m_valid1, m_ready1;
   logic [0:0]  s_data1, m_data1;
   logic [1:0]  level1;

   skid_buffer #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level));
   skid_buffer #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
      .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .level(level8));
   skid_buffer #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
      .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .level(level1));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   logic [31:0] q32[$];
   logic [7:0]  q8[$];
   logic [0:0]  q1[$];
   logic        st32 = 1'b0, st8 = 1'b0, st1 = 1'b0;
   logic [31:0] md32;
   logic [7:0]  md8;
   logic [0:0]  md1;

   // Reset discards everything buffered.
   always @(negedge rst_n) begin
      q32.delete(); q8.delete(); q1.delete();
      st32 = 1'b0; st8 = 1'b0; st1 = 1'b0;
   end

   // Inputs change just after posedge, so at negedge they describe the coming edge.
   always @(negedge clk) if (rst_n === 1'b1) begin
      check("level32", 32'(level), 32'(q32.size()));
      if (st32) begin
         check("stable_v32", 32'(m_valid), 32'd1);
         check("stable_d32", m_data, md32);
      end
      st32 = m_valid & ~m_ready;
      md32 = m_data;
      if (m_valid && m_ready) begin
         check("out32_expected", 32'(q32.size() != 0), 32'd1);
         if (q32.size() != 0) check("data32", m_data, q32.pop_front());
      end
      if (s_valid && s_ready) q32.push_back(s_data);

      check("level8", 32'(level8), 32'(q8.size()));
      if (st8) begin
         check("stable_v8", 32'(m_valid8), 32'd1);
         check("stable_d8", 32'(m_data8), 32'(md8));
      end
      st8 = m_valid8 & ~m_ready8;
      md8 = m_data8;
      if (m_valid8 && m_ready8) begin
         check("out8_expected", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) check("data8", 32'(m_data8), 32'(q8.pop_front()));
      end
      if (s_valid8 && s_ready8) q8.push_back(s_data8);

      check("level1", 32'(level1), 32'(q1.size()));
      if (st1) begin
         check("stable_v1", 32'(m_valid1), 32'd1);
         check("stable_d1", 32'(m_data1), 32'(md1));
      end
      st1 = m_valid1 & ~m_ready1;
      md1 = m_data1;
      if (m_valid1 && m_ready1) begin
         check("out1_expected", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) check("data1", 32'(m_data1), 32'(q1.pop_front()));
      end
      if (s_valid1 && s_ready1) q1.push_back(s_data1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      s_valid8 = 1'b0; s_data8 = '0; m_ready8 = 1'b0;
      s_valid1 = 1'b0; s_data1 = '0; m_ready1 = 1'b0;
      repeat (2) tick();
      check("por_m_valid", 32'(m_valid), 32'd0);
      check("por_level", 32'(level), 32'd0);
      check("por_s_ready", 32'(s_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Reset mid-stream with two words held
      send(32'hDEAD0001);
      send(32'hDEAD0002);
      check("pre_rst_level", 32'(level), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_data", m_data, 32'd0);
      rst_n = 1'b1;
      m_ready = 1'b1;
      send(32'hA5A5A5A5);
      check("post_rst_data", m_data, 32'hA5A5A5A5);
      check("post_rst_valid", 32'(m_valid), 32'd1);
      tick();
      check("post_rst_empty", 32'(m_valid), 32'd0);

      // Streaming at full rate
      for (int i = 1; i <= 8; i++) begin
         s_valid = 1'b1;
         s_data  = 32'(i);
         tick();
         check("stream_data", m_data, 32'(i));
         check("stream_s_ready", 32'(s_ready), 32'd1);
         check("stream_level", 32'(level), 32'd1);
      end
      s_valid = 1'b0;
      tick();
      check("stream_drained", 32'(level), 32'd0);

      // Stall and fill, then release
      m_ready = 1'b0;
      send(32'h11);
      send(32'h22);
      check("fill_level", 32'(level), 32'd2);
      check("fill_s_ready", 32'(s_ready), 32'd0);
      check("fill_data", m_data, 32'h11);
      s_valid = 1'b1;
      s_data  = 32'h33;
      repeat (3) begin
         tick();
         check("blocked_level", 32'(level), 32'd2);
         check("blocked_data", m_data, 32'h11);
      end
      m_ready = 1'b1;
      tick();
      check("release_data", m_data, 32'h22);
      check("release_s_ready", 32'(s_ready), 32'd1);
      tick();
      check("release_data2", m_data, 32'h33);
      check("release_level", 32'(level), 32'd1);
      s_valid = 1'b0;
      tick();

      // Simultaneous in/out while BUSY
      m_ready = 1'b0;
      send(32'h44);
      m_ready = 1'b1;
      send(32'h55);
      check("pass_data", m_data, 32'h55);
      check("pass_level", 32'(level), 32'd1);
      tick();
      check("pass_empty", 32'(level), 32'd0);

      // Drain FULL to EMPTY; m_ready ignored while EMPTY
      m_ready = 1'b0;
      send(32'h66);
      send(32'h77);
      m_ready = 1'b1;
      tick();
      check("drain_data", m_data, 32'h77);
      check("drain_level1", 32'(level), 32'd1);
      tick();
      check("drain_m_valid", 32'(m_valid), 32'd0);
      check("drain_level0", 32'(level), 32'd0);
      tick();
      check("empty_hold", 32'(level), 32'd0);
      m_ready = 1'b0;

      // Random traffic on narrow slices
      for (int i = 0; i < 10000; i++) begin
         s_valid8 = 1'($urandom_range(0, 1));
         s_data8  = 8'($urandom);
         m_ready8 = ($urandom_range(0, 3) != 0);
         s_valid1 = ($urandom_range(0, 3) != 0);
         s_data1  = 1'($urandom);
         m_ready1 = 1'($urandom_range(0, 1));
         tick();
      end
      s_valid8 = 1'b0; s_valid1 = 1'b0;
      m_ready8 = 1'b1; m_ready1 = 1'b1;
      repeat (4) tick();
      check("rand8_drained", 32'(q8.size()), 32'd0);
      check("rand1_drained", 32'(q1.size()), 32'd0);
      check("dir32_drained", 32'(q32.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
